id_ex_pipe: RTL and testbench

Pipeline register between the ID stage and the EX stage of the RISC-V core. Captures the ID output bundle (branch prediction, destination register, PC, operands, immediate, control) under a valid/ready handshake and presents it to EX one cycle later. A two-entry skid buffer lets EX stall without a combinational ready path back into ID. A synchronous flush kills in-flight instructions on branch mispredict, and a saturating counter records EX starvation cycles.

---
 rtl/common_pkg.sv | 47 ++++
 rtl/pipe_skid_buf.sv | 98 +++++++++
 rtl/id_ex_pipe.sv | 79 +++++++
 tb/tb_id_ex_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared core types: branch prediction, decoded control, and the ID/EX
// pipeline payload with its handshake state encoding.
package common;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } branch_predict_type;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [3:0] alu_op;
    } control_type;

    localparam int REG_ID_W = 5;

    typedef struct packed {
        branch_predict_type  branch;
        logic [REG_ID_W-1:0] rd;
        logic [31:0]         pc;
        logic [31:0]         rs1_data;
        logic [31:0]         rs2_data;
        logic [31:0]         imm;
        control_type         control;
    } id_ex_payload_t;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        SKID
    } id_ex_state_e;

    // A killed instruction keeps its stale operands but must decode as a NOP.
    function automatic id_ex_payload_t kill_control(input id_ex_payload_t p);
        id_ex_payload_t r;
        r         = p;
        r.control = '0;
        return r;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with registered upstream ready; the main slot drives
// the downstream side directly so all outputs come straight from flops.
module pipe_skid_buf
    import common::*;
#(
    parameter type payload_t = logic [31:0]
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     flush,
    input  payload_t flush_data,
    input  logic     in_valid,
    output logic     in_ready,
    input  payload_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output payload_t out_data
);

    id_ex_state_e state;
    id_ex_state_e state_next;
    payload_t     skid_data;
    logic         accept;
    logic         issue;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != SKID);
        end
    end

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_next   = FULL;
                    end
                end
                FULL: begin
                    if (accept && issue) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        state_next = SKID;
                    end else if (issue) begin
                        state_next = EMPTY;
                    end
                end
                SKID: begin
                    // in_ready is low here, so only a drain can happen
                    if (issue) begin
                        load_main_skid = 1'b1;
                        state_next     = FULL;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            if (flush) begin
                out_data <= flush_data;
            end else if (load_main_in) begin
                out_data <= in_data;
            end else if (load_main_skid) begin
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: packs the ID bundle into the skid buffer, turns
// flushed entries into NOPs and counts cycles where EX sat idle.
module id_ex_pipe
    import common::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               id_valid,
    output logic               id_ready,
    input  branch_predict_type id_branch_out,
    input  logic [4:0]         id_reg_rd_id,
    input  logic [31:0]        id_pc,
    input  logic [31:0]        id_read_data1,
    input  logic [31:0]        id_read_data2,
    input  logic [31:0]        id_immediate_data,
    input  control_type        id_control_signals,
    input  logic               flush,
    output logic               ex_valid,
    input  logic               ex_ready,
    output branch_predict_type ex_branch_out,
    output logic [4:0]         ex_reg_rd_id,
    output logic [31:0]        ex_pc,
    output logic [31:0]        ex_read_data1,
    output logic [31:0]        ex_read_data2,
    output logic [31:0]        ex_immediate_data,
    output control_type        ex_control_signals,
    output logic [CNT_W-1:0]   bubble_cnt
);

    id_ex_payload_t in_payload;
    id_ex_payload_t out_payload;
    id_ex_payload_t flush_payload;

    assign in_payload = '{
        branch:   id_branch_out,
        rd:       id_reg_rd_id,
        pc:       id_pc,
        rs1_data: id_read_data1,
        rs2_data: id_read_data2,
        imm:      id_immediate_data,
        control:  id_control_signals
    };

    assign flush_payload = kill_control(out_payload);

    pipe_skid_buf #(
        .payload_t(id_ex_payload_t)
    ) u_skid_buf (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .flush_data (flush_payload),
        .in_valid   (id_valid),
        .in_ready   (id_ready),
        .in_data    (in_payload),
        .out_valid  (ex_valid),
        .out_ready  (ex_ready),
        .out_data   (out_payload)
    );

    assign ex_branch_out      = out_payload.branch;
    assign ex_reg_rd_id       = out_payload.rd;
    assign ex_pc              = out_payload.pc;
    assign ex_read_data1      = out_payload.rs1_data;
    assign ex_read_data2      = out_payload.rs2_data;
    assign ex_immediate_data  = out_payload.imm;
    assign ex_control_signals = out_payload.control;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bubble_cnt <= '0;
        end else if (!ex_valid && ex_ready && !flush && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus a randomized
// run against a queue-based model of the two-entry pipe.
module tb_id_ex_pipe;
    import common::*;

    localparam int CNT_W = 4;

    logic               clk      = 1'b0;
    logic               rstn     = 1'b0;
    logic               id_valid = 1'b0;
    logic               flush    = 1'b0;
    logic               ex_ready = 1'b0;
    id_ex_payload_t     in_p     = '0;
    logic               id_ready;
    logic               ex_valid;
    branch_predict_type ex_branch_out;
    logic [4:0]         ex_reg_rd_id;
    logic [31:0]        ex_pc;
    logic [31:0]        ex_read_data1;
    logic [31:0]        ex_read_data2;
    logic [31:0]        ex_immediate_data;
    control_type        ex_control_signals;
    logic [CNT_W-1:0]   bubble_cnt;
    id_ex_payload_t     out_p;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .id_valid           (id_valid),
        .id_ready           (id_ready),
        .id_branch_out      (in_p.branch),
        .id_reg_rd_id       (in_p.rd),
        .id_pc              (in_p.pc),
        .id_read_data1      (in_p.rs1_data),
        .id_read_data2      (in_p.rs2_data),
        .id_immediate_data  (in_p.imm),
        .id_control_signals (in_p.control),
        .flush              (flush),
        .ex_valid           (ex_valid),
        .ex_ready           (ex_ready),
        .ex_branch_out      (ex_branch_out),
        .ex_reg_rd_id       (ex_reg_rd_id),
        .ex_pc              (ex_pc),
        .ex_read_data1      (ex_read_data1),
        .ex_read_data2      (ex_read_data2),
        .ex_immediate_data  (ex_immediate_data),
        .ex_control_signals (ex_control_signals),
        .bubble_cnt         (bubble_cnt)
    );

    assign out_p = {ex_branch_out, ex_reg_rd_id, ex_pc, ex_read_data1,
                    ex_read_data2, ex_immediate_data, ex_control_signals};

    function automatic id_ex_payload_t rand_payload();
        id_ex_payload_t p;
        p.branch.taken  = 1'($urandom());
        p.branch.target = $urandom();
        p.rd            = 5'($urandom());
        p.pc            = $urandom();
        p.rs1_data      = $urandom();
        p.rs2_data      = $urandom();
        p.imm           = $urandom();
        p.control       = 11'($urandom());
        return p;
    endfunction

    // Leaves the pipe out of reset, idle, with id_ready already high.
    task automatic do_reset();
        rstn     = 1'b0;
        id_valid = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        in_p     = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        id_valid = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        in_p     = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (ex_valid !== 1'b0 || id_ready !== 1'b0 || out_p !== '0 || bubble_cnt !== '0) begin
            fails++;
            $display("FAIL reset_values: ex_valid=%b id_ready=%b pc=%h bubble=%0d, required 0/0/0/0",
                     ex_valid, id_ready, ex_pc, bubble_cnt);
        end
        rstn     = 1'b1;
        id_valid = 1'b1;
        in_p.pc  = 32'h100;
        ex_ready = 1'b1;
        #1;
        tests++;
        if (id_ready !== 1'b0 || bubble_cnt !== 4'd0) begin
            fails++;
            $display("FAIL reset_release_pre_edge: id_ready=%b bubble=%0d, required 0/0", id_ready, bubble_cnt);
        end
        @(negedge clk);
        tests++;
        if (id_ready !== 1'b1 || ex_valid !== 1'b0 || bubble_cnt !== 4'd1) begin
            fails++;
            $display("FAIL reset_release_edge1: id_ready=%b ex_valid=%b bubble=%0d, required 1/0/1",
                     id_ready, ex_valid, bubble_cnt);
        end
        @(negedge clk);
        tests++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || bubble_cnt !== 4'd2) begin
            fails++;
            $display("FAIL first_accept: ex_valid=%b ex_pc=%h bubble=%0d, required 1/100/2",
                     ex_valid, ex_pc, bubble_cnt);
        end
        id_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (ex_valid !== 1'b0 || bubble_cnt !== 4'd2) begin
            fails++;
            $display("FAIL drain_no_bubble: ex_valid=%b bubble=%0d, required 0/2", ex_valid, bubble_cnt);
        end
        @(negedge clk);
        tests++;
        if (bubble_cnt !== 4'd3) begin
            fails++;
            $display("FAIL bubble_while_empty: bubble=%0d, required 3", bubble_cnt);
        end
    endtask

    task automatic test_skid();
        do_reset();
        ex_ready     = 1'b1;
        id_valid     = 1'b1;
        in_p         = '0;
        in_p.control = 11'h001;
        in_p.pc      = 32'h0;
        @(negedge clk);
        tests++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h0) begin
            fails++;
            $display("FAIL skid_first: ex_valid=%b ex_pc=%h, required 1/0", ex_valid, ex_pc);
        end
        in_p.pc  = 32'h4;
        ex_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (ex_pc !== 32'h0 || id_ready !== 1'b0) begin
            fails++;
            $display("FAIL skid_absorb: ex_pc=%h id_ready=%b, required 0/0", ex_pc, id_ready);
        end
        in_p.pc = 32'h8;
        repeat (2) @(negedge clk);
        tests++;
        if (ex_pc !== 32'h0 || id_ready !== 1'b0 || ex_valid !== 1'b1) begin
            fails++;
            $display("FAIL skid_hold: ex_pc=%h id_ready=%b ex_valid=%b, required 0/0/1", ex_pc, id_ready, ex_valid);
        end
        ex_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (ex_pc !== 32'h4 || id_ready !== 1'b1 || ex_valid !== 1'b1) begin
            fails++;
            $display("FAIL skid_drain: ex_pc=%h id_ready=%b ex_valid=%b, required 4/1/1", ex_pc, id_ready, ex_valid);
        end
        @(negedge clk);
        tests++;
        if (ex_pc !== 32'h8 || ex_valid !== 1'b1) begin
            fails++;
            $display("FAIL skid_third: ex_pc=%h ex_valid=%b, required 8/1", ex_pc, ex_valid);
        end
        id_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (ex_valid !== 1'b0) begin
            fails++;
            $display("FAIL skid_empty: ex_valid=%b, required 0", ex_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        id_valid     = 1'b1;
        ex_ready     = 1'b0;
        in_p         = '0;
        in_p.control = 11'h7ff;
        in_p.pc      = 32'h10;
        @(negedge clk);
        in_p.pc = 32'h14;
        @(negedge clk);
        tests++;
        if (id_ready !== 1'b0 || ex_pc !== 32'h10) begin
            fails++;
            $display("FAIL flush_setup: id_ready=%b ex_pc=%h, required 0/10", id_ready, ex_pc);
        end
        flush    = 1'b1;
        ex_ready = 1'b1;
        in_p.pc  = 32'h20;
        @(negedge clk);
        tests++;
        if (ex_valid !== 1'b0 || ex_control_signals !== '0 || id_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_skid: ex_valid=%b ctrl=%h id_ready=%b, required 0/0/1",
                     ex_valid, ex_control_signals, id_ready);
        end
        flush    = 1'b0;
        id_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (ex_valid !== 1'b0 || ex_pc === 32'h20 || ex_control_signals !== '0) begin
                fails++;
                $display("FAIL flush_no_leak: cycle=%0d ex_valid=%b ex_pc=%h ctrl=%h, required 0/not 20/0",
                         i, ex_valid, ex_pc, ex_control_signals);
            end
        end
    endtask

    task automatic test_bubble_sat();
        do_reset();
        ex_ready = 1'b1;
        id_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            tests++;
            if (bubble_cnt !== CNT_W'((i > 15) ? 15 : i)) begin
                fails++;
                $display("FAIL bubble_sat: cycle=%0d bubble=%0d, required %0d", i, bubble_cnt, (i > 15) ? 15 : i);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ex_ready     = 1'b0;
        id_valid     = 1'b1;
        in_p         = rand_payload();
        in_p.pc      = 32'habc;
        in_p.control = 11'h7ff;
        @(negedge clk);
        id_valid = 1'b0;
        tests++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'habc) begin
            fails++;
            $display("FAIL async_setup: ex_valid=%b ex_pc=%h, required 1/abc", ex_valid, ex_pc);
        end
        #2 rstn = 1'b0;
        #1;
        tests++;
        if (ex_valid !== 1'b0 || out_p !== '0 || bubble_cnt !== '0 || id_ready !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: ex_valid=%b ex_pc=%h ctrl=%h bubble=%0d id_ready=%b, required all 0",
                     ex_valid, ex_pc, ex_control_signals, bubble_cnt, id_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_random();
        id_ex_payload_t q[$];
        logic           exp_ready;
        logic           ctrl_zero;
        logic           acc;
        logic           iss;
        int             exp_bub;
        do_reset();
        exp_ready = 1'b1;
        ctrl_zero = 1'b1;
        exp_bub   = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            tests++;
            if (ex_valid !== (q.size() > 0) || id_ready !== exp_ready || bubble_cnt !== CNT_W'(exp_bub)) begin
                fails++;
                $display("FAIL rand_ctrl: cycle=%0d ex_valid=%b id_ready=%b bubble=%0d, required %b/%b/%0d",
                         cyc, ex_valid, id_ready, bubble_cnt, (q.size() > 0), exp_ready, exp_bub);
            end
            if (q.size() > 0) begin
                tests++;
                if (out_p !== q[0]) begin
                    fails++;
                    $display("FAIL rand_payload: cycle=%0d ex_pc=%h ctrl=%h, required pc=%h ctrl=%h",
                             cyc, ex_pc, ex_control_signals, q[0].pc, q[0].control);
                end
            end else if (ctrl_zero) begin
                tests++;
                if (ex_control_signals !== '0) begin
                    fails++;
                    $display("FAIL rand_nop: cycle=%0d ctrl=%h, required 0", cyc, ex_control_signals);
                end
            end
            if (fails > 40) break;
            id_valid = ($urandom_range(0, 9) < 7);
            ex_ready = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 99) < 4);
            in_p     = rand_payload();
            acc = id_valid && exp_ready;
            iss = (q.size() > 0) && ex_ready;
            if ((q.size() == 0) && ex_ready && !flush && exp_bub != 15) exp_bub++;
            if (flush) begin
                q.delete();
                ctrl_zero = 1'b1;
            end else begin
                if (iss) void'(q.pop_front());
                if (acc) q.push_back(in_p);
            end
            if (q.size() != 0) ctrl_zero = 1'b0;
            exp_ready = (q.size() != 2);
            @(negedge clk);
        end
        id_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_skid();
        test_flush();
        test_bubble_sat();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
